// File: rtl/spi_shift_engine.sv
// Parameterised SPI-style shift engine: parallel load, WIDTH-bit serial exchange in either bit
// order, abort, and a one-cycle completion pulse.
module spi_shift_engine #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] P_DATA_IN,
  input  logic             S_DATA_IN,
  input  logic             SHIFT_EN,
  input  logic             ABORT,
  output logic [WIDTH-1:0] P_DATA_OUT,
  output logic             S_DATA_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShifting, StComplete} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    shreg_shifted = shreg_q;
    if (LSB_FIRST) begin
      shreg_shifted = {S_DATA_IN, shreg_q[WIDTH-1:1]};
    end else begin
      shreg_shifted = {shreg_q[WIDTH-2:0], S_DATA_IN};
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StComplete: begin
          // A load in the DONE cycle starts the next transfer without an idle gap.
          if (LOAD) begin
            shreg_q <= P_DATA_IN;
            cnt_q   <= '0;
            state_q <= StShifting;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StShifting: begin
          // Abort wins over a coincident strobe; the partial word is left visible.
          if (ABORT) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (SHIFT_EN) begin
            shreg_q <= shreg_shifted;
            if (cnt_q == LastCnt) begin
              cnt_q   <= '0;
              state_q <= StComplete;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign P_DATA_OUT = shreg_q;
  assign S_DATA_OUT = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: four instances (8 MSB, 8 LSB, 2, 32) on shared controls.
module tb_spi_shift_engine;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        load = 1'b0;
  logic        sdi = 1'b0;
  logic        sen = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  pdi8 = '0;
  logic [1:0]  pdi2 = '0;
  logic [31:0] pdi32 = '0;

  logic [7:0]  pdo_m, pdo_l;
  logic [1:0]  pdo_2;
  logic [31:0] pdo_w;
  logic        sdo_m, sdo_l, sdo_2, sdo_w;
  logic        busy_m, busy_l, busy_2, busy_w;
  logic        done_m, done_l, done_2, done_w;

  int unsigned passes = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  spi_shift_engine #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb8 (
    .CLK(clk), .CLR_N(clr_n), .LOAD(load), .P_DATA_IN(pdi8), .S_DATA_IN(sdi),
    .SHIFT_EN(sen), .ABORT(abort), .P_DATA_OUT(pdo_m), .S_DATA_OUT(sdo_m),
    .BUSY(busy_m), .DONE(done_m)
  );
  spi_shift_engine #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb8 (
    .CLK(clk), .CLR_N(clr_n), .LOAD(load), .P_DATA_IN(pdi8), .S_DATA_IN(sdi),
    .SHIFT_EN(sen), .ABORT(abort), .P_DATA_OUT(pdo_l), .S_DATA_OUT(sdo_l),
    .BUSY(busy_l), .DONE(done_l)
  );
  spi_shift_engine #(.WIDTH(2), .LSB_FIRST(1'b0)) u_w2 (
    .CLK(clk), .CLR_N(clr_n), .LOAD(load), .P_DATA_IN(pdi2), .S_DATA_IN(sdi),
    .SHIFT_EN(sen), .ABORT(abort), .P_DATA_OUT(pdo_2), .S_DATA_OUT(sdo_2),
    .BUSY(busy_2), .DONE(done_2)
  );
  spi_shift_engine #(.WIDTH(32), .LSB_FIRST(1'b0)) u_w32 (
    .CLK(clk), .CLR_N(clr_n), .LOAD(load), .P_DATA_IN(pdi32), .S_DATA_IN(sdi),
    .SHIFT_EN(sen), .ABORT(abort), .P_DATA_OUT(pdo_w), .S_DATA_OUT(sdo_w),
    .BUSY(busy_w), .DONE(done_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load  = 1'b0;
    sen   = 1'b0;
    abort = 1'b0;
    sdi   = 1'b0;
    clr_n = 1'b0;
    #2;
    clr_n = 1'b1;
  endtask

  initial begin
    logic [7:0] bits_in;
    logic [7:0] sdo_exp;
    logic [7:0] e;

    tick();
    check("rst_pdo", {24'd0, pdo_m}, 32'h0);
    check("rst_sdo", {31'd0, sdo_m}, 32'h0);
    check("rst_busy", {31'd0, busy_m}, 32'h0);
    check("rst_done", {31'd0, done_m}, 32'h0);
    do_reset();

    // MSB-first 0xA5 exchanged for 0x3C
    load = 1'b1; pdi8 = 8'hA5; tick(); load = 1'b0;
    bits_in = 8'b0011_1100;
    sdo_exp = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check("t1_busy", {31'd0, busy_m}, 32'h1);
      check("t1_sdo", {31'd0, sdo_m}, {31'd0, sdo_exp[7-i]});
      check("t1_nodone", {31'd0, done_m}, 32'h0);
      sen = 1'b1; sdi = bits_in[7-i]; tick();
    end
    sen = 1'b0;
    check("t1_done", {31'd0, done_m}, 32'h1);
    check("t1_busy_lo", {31'd0, busy_m}, 32'h0);
    check("t1_pdo", {24'd0, pdo_m}, 32'h3C);
    tick();
    check("t1_done_once", {31'd0, done_m}, 32'h0);
    check("t1_pdo_hold", {24'd0, pdo_m}, 32'h3C);

    // LSB-first 0x0F with ones shifted in
    do_reset();
    load = 1'b1; pdi8 = 8'h0F; tick(); load = 1'b0;
    sdo_exp = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      check("t2_sdo", {31'd0, sdo_l}, {31'd0, sdo_exp[i]});
      check("t2_nodone", {31'd0, done_l}, 32'h0);
      sen = 1'b1; sdi = 1'b1; tick();
    end
    sen = 1'b0;
    check("t2_done", {31'd0, done_l}, 32'h1);
    check("t2_pdo", {24'd0, pdo_l}, 32'hFF);
    tick();
    check("t2_done_once", {31'd0, done_l}, 32'h0);

    // Gapped strobe, stray LOAD mid-transfer
    do_reset();
    load = 1'b1; pdi8 = 8'h81; tick(); load = 1'b0; sdi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = 8'h81 << i;
      check("t3_pdo", {24'd0, pdo_m}, {24'd0, e});
      check("t3_busy", {31'd0, busy_m}, 32'h1);
      check("t3_nodone", {31'd0, done_m}, 32'h0);
      for (int g = 0; g < 2; g++) begin
        sen = 1'b0;
        load = (i == 3 && g == 0);
        pdi8 = 8'hFF;
        tick();
      end
      load = 1'b0;
      sen = 1'b1; tick(); sen = 1'b0;
    end
    check("t3_done", {31'd0, done_m}, 32'h1);
    check("t3_pdo_end", {24'd0, pdo_m}, 32'h00);

    // Abort after three shifts, then a fresh transfer
    do_reset();
    load = 1'b1; pdi8 = 8'hF0; tick(); load = 1'b0;
    sen = 1'b1; sdi = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0; sen = 1'b0;
    check("t4_busy", {31'd0, busy_m}, 32'h0);
    check("t4_pdo", {24'd0, pdo_m}, 32'h80);
    check("t4_nodone", {31'd0, done_m}, 32'h0);
    tick();
    check("t4_nodone2", {31'd0, done_m}, 32'h0);
    load = 1'b1; pdi8 = 8'h55; tick(); load = 1'b0;
    check("t4_reload", {24'd0, pdo_m}, 32'h55);
    check("t4_rebusy", {31'd0, busy_m}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("t4_nodone3", {31'd0, done_m}, 32'h0);
      sen = 1'b1; tick();
    end
    sen = 1'b0;
    check("t4_done", {31'd0, done_m}, 32'h1);
    check("t4_pdo_end", {24'd0, pdo_m}, 32'h00);

    // Asynchronous clear mid-transfer
    do_reset();
    load = 1'b1; pdi8 = 8'hC3; tick(); load = 1'b0;
    sen = 1'b1; sdi = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t5_pre_pdo", {24'd0, pdo_m}, 32'h7F);
    check("t5_pre_busy", {31'd0, busy_m}, 32'h1);
    #1; clr_n = 1'b0; #1;
    check("t5_pdo", {24'd0, pdo_m}, 32'h0);
    check("t5_sdo", {31'd0, sdo_m}, 32'h0);
    check("t5_busy", {31'd0, busy_m}, 32'h0);
    check("t5_done", {31'd0, done_m}, 32'h0);
    #3; clr_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_post_done", {31'd0, done_m}, 32'h0);
      check("t5_post_busy", {31'd0, busy_m}, 32'h0);
    end
    sen = 1'b0;

    // Back-to-back: load in the DONE cycle, WIDTH 8
    do_reset();
    load = 1'b1; pdi8 = 8'hA5; tick(); load = 1'b0;
    sen = 1'b1; sdi = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    sen = 1'b0;
    check("t6_done", {31'd0, done_m}, 32'h1);
    check("t6_pdo", {24'd0, pdo_m}, 32'hFF);
    load = 1'b1; pdi8 = 8'h12; tick(); load = 1'b0;
    check("t6_pdo_b2b", {24'd0, pdo_m}, 32'h12);
    check("t6_busy_b2b", {31'd0, busy_m}, 32'h1);
    check("t6_done_b2b", {31'd0, done_m}, 32'h0);
    tick();
    check("t6_done_b2b2", {31'd0, done_m}, 32'h0);

    // WIDTH 2 smoke
    do_reset();
    load = 1'b1; pdi2 = 2'b01; tick(); load = 1'b0;
    check("w2_sdo", {31'd0, sdo_2}, 32'h0);
    sen = 1'b1; sdi = 1'b1; tick();
    check("w2_nodone", {31'd0, done_2}, 32'h0);
    sdi = 1'b0; tick(); sen = 1'b0;
    check("w2_done", {31'd0, done_2}, 32'h1);
    check("w2_pdo", {30'd0, pdo_2}, 32'h2);
    load = 1'b1; pdi2 = 2'b10; tick(); load = 1'b0;
    check("w2_pdo_b2b", {30'd0, pdo_2}, 32'h2);
    check("w2_busy_b2b", {31'd0, busy_2}, 32'h1);
    check("w2_done_b2b", {31'd0, done_2}, 32'h0);

    // WIDTH 32 smoke
    do_reset();
    load = 1'b1; pdi32 = 32'hA5A5_0F0F; tick(); load = 1'b0;
    check("w32_sdo", {31'd0, sdo_w}, 32'h1);
    sen = 1'b1; sdi = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    check("w32_nodone", {31'd0, done_w}, 32'h0);
    check("w32_busy", {31'd0, busy_w}, 32'h1);
    tick(); sen = 1'b0;
    check("w32_done", {31'd0, done_w}, 32'h1);
    check("w32_pdo", pdo_w, 32'hFFFF_FFFF);
    load = 1'b1; pdi32 = 32'h12; tick(); load = 1'b0;
    check("w32_pdo_b2b", pdo_w, 32'h12);
    check("w32_busy_b2b", {31'd0, busy_w}, 32'h1);
    check("w32_done_b2b", {31'd0, done_w}, 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning shift word length in bits, legal range 2..32.
REQ-002 SHALL have parameter LSB_FIRST, default 0, meaning 0 = MSB shifted out/in first, 1 = LSB first.
REQ-003 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port CLR_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port LOAD  input  1  synchronous parallel load plus start-of-transfer request.
REQ-006 SHALL have port P_DATA_IN  input  WIDTH  parallel word captured on accepted LOAD.
REQ-007 SHALL have port S_DATA_IN  input  1  serial input bit, sampled on each accepted shift.
REQ-008 SHALL have port SHIFT_EN  input  1  shift strobe, one bit per cycle it is high while shifting.
REQ-009 SHALL have port ABORT  input  1  synchronous cancel of a transfer in progress.
REQ-010 SHALL have port P_DATA_OUT  output  WIDTH  current shift register contents.
REQ-011 SHALL have port S_DATA_OUT  output  1  serial output bit, the bit next to leave the register.
REQ-012 SHALL have port BUSY  output  1  high while in SHIFTING.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse on transfer completion.

Function
REQ-014 SHALL implement states IDLE, SHIFTING, COMPLETE, plus a bit counter of ceil(log2(WIDTH)) bits.
REQ-015 SHALL, in IDLE or COMPLETE with LOAD=1: register <= P_DATA_IN, counter <= 0, next state SHIFTING.
REQ-016 SHALL, in IDLE with LOAD=0, hold register and remain in IDLE; SHIFT_EN and ABORT ignored.
REQ-017 SHALL, in SHIFTING with SHIFT_EN=1, ABORT=0, LSB_FIRST=0: register <= {register[WIDTH-2:0], S_DATA_IN}.
REQ-018 SHALL, in SHIFTING with SHIFT_EN=1, ABORT=0, LSB_FIRST=1: register <= {S_DATA_IN, register[WIDTH-1:1]}.
REQ-019 SHALL increment the counter on every accepted shift; SHIFT_EN=0 cycles hold register and counter (gaps allowed, unbounded).
REQ-020 SHALL move SHIFTING -> COMPLETE on the accepted shift where counter = WIDTH-1 (exactly WIDTH shifts per transfer).
REQ-021 SHALL drive DONE=1 in the COMPLETE state only (one cycle, the cycle after the final shift edge), then return to IDLE unless LOAD=1.
REQ-022 SHALL drive S_DATA_OUT combinationally: register[WIDTH-1] when LSB_FIRST=0, register[0] when LSB_FIRST=1.
REQ-023 SHALL drive BUSY = (state == SHIFTING), no combinational path from inputs.
REQ-024 SHALL ignore LOAD while in SHIFTING (no restart mid-transfer).
REQ-025 SHALL, in SHIFTING with ABORT=1, go to IDLE with counter <= 0, register held, no shift that cycle, DONE never asserted; ABORT has priority over SHIFT_EN.
REQ-026 SHALL, with LOAD and SHIFT_EN both high in IDLE/COMPLETE, perform the load only (no shift that cycle).
REQ-027 SHALL keep P_DATA_OUT equal to the fully received word during the DONE cycle and after, until next LOAD.

Reset
REQ-028 SHALL, while CLR_N=0, immediately force state IDLE, register 0, counter 0, BUSY 0, DONE 0, hence P_DATA_OUT 0 and S_DATA_OUT 0.
REQ-029 SHALL, on CLR_N assertion mid-transfer, abandon the transfer with no DONE pulse; first LOAD accepted is on the first rising edge with CLR_N=1.

Verification
REQ-030 SHALL cover WIDTH=8, LSB_FIRST=0: LOAD 0xA5, 8 consecutive SHIFT_EN with S_DATA_IN 0,0,1,1,1,1,0,0 -> S_DATA_OUT 1,0,1,0,0,1,0,1; P_DATA_OUT=0x3C; DONE one cycle after 8th shift; BUSY high for exactly 8 cycles.
REQ-031 SHALL cover WIDTH=8, LSB_FIRST=1: LOAD 0x0F, S_DATA_IN=1 for 8 shifts -> S_DATA_OUT 1,1,1,1,0,0,0,0; P_DATA_OUT=0xFF; single DONE pulse.
REQ-032 SHALL cover gapped strobe: LOAD 0x81, SHIFT_EN high every third cycle, S_DATA_IN=0 -> DONE only after 8th strobe, P_DATA_OUT=0x00, LOAD during SHIFTING ignored.
REQ-033 SHALL cover ABORT after 3 shifts of 0xF0 (S_DATA_IN=0) -> IDLE, BUSY 0, P_DATA_OUT=0x80, no DONE; next LOAD 0x55 starts fresh 8-shift transfer.
REQ-034 SHALL cover CLR_N low asynchronously after 5 shifts -> all outputs 0 before next edge, no DONE after release.
REQ-035 SHALL cover back-to-back: LOAD 0x12 asserted in DONE cycle of prior transfer -> register=0x12, BUSY high next cycle, DONE not repeated; WIDTH=2 and WIDTH=32 smoke runs of the same sequence.
